// File: rtl/fft_pkg.sv
// fft_pkg
// Fixed-point helpers shared by the radix-2 streaming butterfly stage:
//   f_log2        - ceil(log2(v)), exact for powers of two
//   f_ow          - butterfly output width derived from DW and GUARD
//   f_tw_one      - twiddle value representing 1.0 (2^(TW-2))
//   f_round_shift - round-half-up arithmetic right shift (no rounding when s = 0)
package fft_pkg;

    function automatic int unsigned f_log2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned f_ow(input int unsigned dw, input int unsigned guard);
        return dw + guard + 2;
    endfunction

    function automatic int unsigned f_tw_one(input int unsigned tw);
        return 32'd1 << (tw - 2);
    endfunction

    // Adds half an LSB of the result before the arithmetic shift.
    function automatic logic signed [63:0] f_round_shift(input logic signed [63:0] m,
                                                         input int unsigned s);
        if (s == 0) return m;
        return (m + (64'sd1 <<< (s - 1))) >>> s;
    endfunction

endpackage

// File: rtl/fft_r2_stream_stage_if.sv
// fft_r2_stream_stage_if
// Streaming bus of the radix-2 butterfly stage.
//   in_valid/in_ready/in_last     - input handshake, in_last marks the final pair of a frame
//   a_r/a_i/b_r/b_i               - butterfly pair (DW signed each)
//   tw_bypass                     - force W = 1.0 for this transfer
//   tw_addr                       - pair index k towards an external twiddle ROM
//   tw_r/tw_i                     - twiddle W_N^k (TW signed each), same cycle as tw_addr
//   out_valid/out_ready/out_last  - output handshake
//   p_r/p_i/n_r/n_i               - p = a + b*W, n = a - b*W (OW signed each)
//   err_frame                     - sticky frame-alignment error
// Modports: slave = the stage itself, master = the producer/consumer environment.
interface fft_r2_stream_stage_if import fft_pkg::*; #(
    parameter int unsigned N     = 16,
    parameter int unsigned DW    = 9,
    parameter int unsigned TW    = 10,
    parameter int unsigned GUARD = 5
) ();

    localparam int unsigned OW = f_ow(DW, GUARD);
    localparam int unsigned KW = f_log2(N) - 1;

    logic                 in_valid;
    logic                 in_ready;
    logic                 in_last;
    logic signed [DW-1:0] a_r;
    logic signed [DW-1:0] a_i;
    logic signed [DW-1:0] b_r;
    logic signed [DW-1:0] b_i;
    logic                 tw_bypass;
    logic [KW-1:0]        tw_addr;
    logic signed [TW-1:0] tw_r;
    logic signed [TW-1:0] tw_i;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic signed [OW-1:0] p_r;
    logic signed [OW-1:0] p_i;
    logic signed [OW-1:0] n_r;
    logic signed [OW-1:0] n_i;
    logic                 err_frame;

    modport slave (
        input  in_valid, in_last, a_r, a_i, b_r, b_i, tw_bypass, tw_r, tw_i, out_ready,
        output in_ready, tw_addr, out_valid, out_last, p_r, p_i, n_r, n_i, err_frame
    );

    modport master (
        output in_valid, in_last, a_r, a_i, b_r, b_i, tw_bypass, tw_r, tw_i, out_ready,
        input  in_ready, tw_addr, out_valid, out_last, p_r, p_i, n_r, n_i, err_frame
    );

endinterface

// File: rtl/fft_cmul.sv
// fft_cmul
// Registered complex multiplier b*W with rounding back to the butterfly scale.
// The full-precision product (DW+TW+1 bits) is shifted right by TW-2-GUARD with
// round-half-up, so the result carries the same 2^GUARD scale as the a-path.
//   clk, rst_n     - clock, asynchronous active-low reset
//   i_en           - load enable (pipeline advance)
//   i_b_r, i_b_i   - multiplicand b (DW signed)
//   i_w_r, i_w_i   - twiddle W (TW signed, 1.0 = 2^(TW-2))
//   o_bw_r, o_bw_i - rounded product (OW signed), registered
module fft_cmul import fft_pkg::*; #(
    parameter int unsigned DW    = 9,
    parameter int unsigned TW    = 10,
    parameter int unsigned GUARD = 5,
    parameter int unsigned OW    = DW + GUARD + 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic signed [DW-1:0] i_b_r,
    input  logic signed [DW-1:0] i_b_i,
    input  logic signed [TW-1:0] i_w_r,
    input  logic signed [TW-1:0] i_w_i,
    output logic signed [OW-1:0] o_bw_r,
    output logic signed [OW-1:0] o_bw_i
);

    localparam int unsigned MW = DW + TW + 1;
    localparam int unsigned S  = TW - 2 - GUARD;

    logic signed [MW-1:0] w_mr;
    logic signed [MW-1:0] w_mi;
    logic signed [OW-1:0] r_bw_r;
    logic signed [OW-1:0] r_bw_i;

    assign w_mr = MW'(i_b_r) * MW'(i_w_r) - MW'(i_b_i) * MW'(i_w_i);
    assign w_mi = MW'(i_b_r) * MW'(i_w_i) + MW'(i_b_i) * MW'(i_w_r);

    // With |W| <= 1.0 the rounded product always fits OW bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bw_r <= '0;
            r_bw_i <= '0;
        end else if (i_en) begin
            r_bw_r <= OW'(f_round_shift(64'(w_mr), S));
            r_bw_i <= OW'(f_round_shift(64'(w_mi), S));
        end
    end

    assign o_bw_r = r_bw_r;
    assign o_bw_i = r_bw_i;

endmodule

// File: rtl/fft_r2_stream_stage.sv
// fft_r2_stream_stage
// One radix-2 DIT butterfly stage for a streaming FFT of size N, one pair per cycle.
// Pipeline: S1 input register, S2 complex multiply + rounding (fft_cmul), S3 add/sub.
// All stages advance together; a stalled output freezes the whole pipe.
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - streaming bus (slave side): input pair + twiddle, output p/n, err_frame
module fft_r2_stream_stage import fft_pkg::*; #(
    parameter int unsigned N     = 16,
    parameter int unsigned DW    = 9,
    parameter int unsigned TW    = 10,
    parameter int unsigned GUARD = 5
) (
    input logic                  clk,
    input logic                  rst_n,
    fft_r2_stream_stage_if.slave bus
);

    localparam int unsigned OW = f_ow(DW, GUARD);
    localparam int unsigned KW = f_log2(N) - 1;
    localparam logic [KW-1:0] KLast = KW'(N / 2 - 1);
    localparam logic signed [TW-1:0] WOne = TW'(f_tw_one(TW));

    logic w_adv;
    logic w_xfer;
    logic w_k_last;

    logic [KW-1:0] r_k;
    logic          r_err;

    // S1
    logic                 r_s1_valid;
    logic                 r_s1_last;
    logic                 r_s1_bypass;
    logic signed [DW-1:0] r_s1_a_r;
    logic signed [DW-1:0] r_s1_a_i;
    logic signed [DW-1:0] r_s1_b_r;
    logic signed [DW-1:0] r_s1_b_i;
    logic signed [TW-1:0] r_s1_tw_r;
    logic signed [TW-1:0] r_s1_tw_i;
    logic signed [TW-1:0] w_w_r;
    logic signed [TW-1:0] w_w_i;

    // S2
    logic                 r_s2_valid;
    logic                 r_s2_last;
    logic signed [DW-1:0] r_s2_a_r;
    logic signed [DW-1:0] r_s2_a_i;
    logic signed [OW-1:0] w_bw_r;
    logic signed [OW-1:0] w_bw_i;
    logic signed [OW-1:0] w_a_s_r;
    logic signed [OW-1:0] w_a_s_i;

    // S3
    logic                 r_s3_valid;
    logic                 r_s3_last;
    logic signed [OW-1:0] r_p_r;
    logic signed [OW-1:0] r_p_i;
    logic signed [OW-1:0] r_n_r;
    logic signed [OW-1:0] r_n_i;

    assign w_adv    = !r_s3_valid || bus.out_ready;
    assign w_xfer   = bus.in_valid && w_adv;
    assign w_k_last = (r_k == KLast);

    // Pair counter and sticky frame check. in_last always restarts the frame so a
    // misaligned source resynchronises on its own next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k   <= '0;
            r_err <= 1'b0;
        end else if (w_xfer) begin
            if (bus.in_last != w_k_last) r_err <= 1'b1;
            r_k <= (bus.in_last || w_k_last) ? '0 : r_k + KW'(1);
        end
    end

    // S1: capture the transfer as presented, twiddle included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_bypass <= 1'b0;
            r_s1_a_r    <= '0;
            r_s1_a_i    <= '0;
            r_s1_b_r    <= '0;
            r_s1_b_i    <= '0;
            r_s1_tw_r   <= '0;
            r_s1_tw_i   <= '0;
        end else if (w_adv) begin
            r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_s1_last   <= bus.in_last;
                r_s1_bypass <= bus.tw_bypass;
                r_s1_a_r    <= bus.a_r;
                r_s1_a_i    <= bus.a_i;
                r_s1_b_r    <= bus.b_r;
                r_s1_b_i    <= bus.b_i;
                r_s1_tw_r   <= bus.tw_r;
                r_s1_tw_i   <= bus.tw_i;
            end
        end
    end

    assign w_w_r = r_s1_bypass ? WOne : r_s1_tw_r;
    assign w_w_i = r_s1_bypass ? '0 : r_s1_tw_i;

    // S2: the a-path and framing bits ride alongside the multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_a_r   <= '0;
            r_s2_a_i   <= '0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            r_s2_a_r   <= r_s1_a_r;
            r_s2_a_i   <= r_s1_a_i;
        end
    end

    fft_cmul #(
        .DW    (DW),
        .TW    (TW),
        .GUARD (GUARD),
        .OW    (OW)
    ) u_cmul (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_adv),
        .i_b_r  (r_s1_b_r),
        .i_b_i  (r_s1_b_i),
        .i_w_r  (w_w_r),
        .i_w_i  (w_w_i),
        .o_bw_r (w_bw_r),
        .o_bw_i (w_bw_i)
    );

    // Bring a onto the same 2^GUARD scale as the rounded product.
    assign w_a_s_r = OW'(r_s2_a_r) <<< GUARD;
    assign w_a_s_i = OW'(r_s2_a_i) <<< GUARD;

    // S3: butterfly. Data only moves with a valid pair so bubbles leave outputs untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_valid <= 1'b0;
            r_s3_last  <= 1'b0;
            r_p_r      <= '0;
            r_p_i      <= '0;
            r_n_r      <= '0;
            r_n_i      <= '0;
        end else if (w_adv) begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_s3_last <= r_s2_last;
                r_p_r     <= w_a_s_r + w_bw_r;
                r_p_i     <= w_a_s_i + w_bw_i;
                r_n_r     <= w_a_s_r - w_bw_r;
                r_n_i     <= w_a_s_i - w_bw_i;
            end
        end
    end

    assign bus.in_ready  = w_adv;
    assign bus.tw_addr   = r_k;
    assign bus.out_valid = r_s3_valid;
    assign bus.out_last  = r_s3_last;
    assign bus.p_r       = r_p_r;
    assign bus.p_i       = r_p_i;
    assign bus.n_r       = r_n_r;
    assign bus.n_i       = r_n_i;
    assign bus.err_frame = r_err;

endmodule

// File: tb/tb_fft_r2_stream_stage.sv
// tb_fft_r2_stream_stage
// Scoreboard bench: every accepted input pair pushes its expected butterfly result
// (computed with plain integer arithmetic) into a queue; a monitor pops and compares
// whenever an output is consumed, and checks stall stability, tw_addr and err_frame.
module tb_fft_r2_stream_stage;

    localparam int unsigned N     = 16;
    localparam int unsigned DW    = 9;
    localparam int unsigned TW    = 10;
    localparam int unsigned GUARD = 5;
    localparam int unsigned HALF  = N / 2;
    localparam int          S     = TW - 2 - GUARD;

    typedef struct {
        int p_r;
        int p_i;
        int n_r;
        int n_i;
        bit last;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_r2_stream_stage_if #(.N(N), .DW(DW), .TW(TW), .GUARD(GUARD)) bus ();

    fft_r2_stream_stage #(.N(N), .DW(DW), .TW(TW), .GUARD(GUARD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   n_stall  = 0;
    int   kexp     = 0;
    bit   err_exp  = 1'b0;
    int   rdy_mode = 0;   // 0: always ready, 1: hold off, 2: random
    exp_t q[$];
    exp_t held;
    bit   held_v   = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // floor((m + 2^(S-1)) / 2^S) done with division, independent of shift semantics
    function automatic longint round_ref(input longint m);
        longint d, t, qv;
        if (S == 0) return m;
        d  = longint'(1) << S;
        t  = m + d / 2;
        qv = t / d;
        if ((t % d) != 0 && t < 0) qv = qv - 1;
        return qv;
    endfunction

    function automatic exp_t model(input int ar, input int ai, input int br, input int bi,
                                   input int wr_in, input int wi_in, input bit byp,
                                   input bit last);
        exp_t   e;
        int     wr, wi;
        longint mr, mi, bwr, bwi, asr, asi;
        wr  = byp ? (1 << (TW - 2)) : wr_in;
        wi  = byp ? 0 : wi_in;
        mr  = longint'(br) * wr - longint'(bi) * wi;
        mi  = longint'(br) * wi + longint'(bi) * wr;
        bwr = round_ref(mr);
        bwi = round_ref(mi);
        asr = longint'(ar) * (1 << GUARD);
        asi = longint'(ai) * (1 << GUARD);
        e.p_r  = int'(asr + bwr);
        e.p_i  = int'(asi + bwi);
        e.n_r  = int'(asr - bwr);
        e.n_i  = int'(asi - bwi);
        e.last = last;
        return e;
    endfunction

    // Ready generator; the only driver of out_ready.
    always begin
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'b0;
            default: bus.out_ready = ($urandom_range(0, 3) != 0);
        endcase
        @(posedge clk);
        #2;
    end

    // Monitor + scoreboard, sampling on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            kexp    = 0;
            err_exp = 1'b0;
            held_v  = 1'b0;
        end else begin
            chk("err_frame", bus.err_frame, err_exp);
            if (held_v) begin
                chk("stall_out_valid", bus.out_valid, 1);
                chk("stall_p_r", bus.p_r, held.p_r);
                chk("stall_p_i", bus.p_i, held.p_i);
                chk("stall_n_r", bus.n_r, held.n_r);
                chk("stall_n_i", bus.n_i, held.n_i);
                chk("stall_last", bus.out_last, held.last);
            end
            held_v = 1'b0;
            if (bus.out_valid) begin
                if (!bus.out_ready) begin
                    n_stall++;
                    chk("stall_in_ready", bus.in_ready, 0);
                    held.p_r  = bus.p_r;
                    held.p_i  = bus.p_i;
                    held.n_r  = bus.n_r;
                    held.n_i  = bus.n_i;
                    held.last = bus.out_last;
                    held_v    = 1'b1;
                end else begin
                    chk("out_expected", q.size() > 0, 1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        chk("out_p_r", bus.p_r, e.p_r);
                        chk("out_p_i", bus.p_i, e.p_i);
                        chk("out_n_r", bus.n_r, e.n_r);
                        chk("out_n_i", bus.n_i, e.n_i);
                        chk("out_last", bus.out_last, e.last);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                chk("tw_addr", bus.tw_addr, kexp);
                e = model(int'(bus.a_r), int'(bus.a_i), int'(bus.b_r), int'(bus.b_i),
                          int'(bus.tw_r), int'(bus.tw_i), bus.tw_bypass, bus.in_last);
                q.push_back(e);
                if (bus.in_last != (kexp == HALF - 1)) err_exp = 1'b1;
                kexp = (bus.in_last || kexp == HALF - 1) ? 0 : kexp + 1;
            end
        end
    end

    task automatic send_pair(input int ar, input int ai, input int br, input int bi,
                             input int wr, input int wi, input bit byp, input bit last);
        bit done;
        done          = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a_r       = DW'(ar);
        bus.a_i       = DW'(ai);
        bus.b_r       = DW'(br);
        bus.b_i       = DW'(bi);
        bus.tw_r      = TW'(wr);
        bus.tw_i      = TW'(wi);
        bus.tw_bypass = byp;
        bus.in_last   = last;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            done = bus.in_ready;
            @(posedge clk);
            #1;
        end
        chk("in_accept", done, 1);
        bus.in_valid = 1'b0;
    endtask

    // last_sel: 0/1 forces in_last, 2 follows the frame position
    task automatic send_random(input int last_sel);
        int ar, ai, br, bi, wr, wi;
        bit byp, last;
        ar   = int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW - 1));
        ai   = int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW - 1));
        br   = int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW - 1));
        bi   = int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW - 1));
        wr   = int'($urandom_range(0, 362)) - 181;
        wi   = int'($urandom_range(0, 362)) - 181;
        byp  = ($urandom_range(0, 7) == 0);
        last = (last_sel == 2) ? (kexp == HALF - 1) : last_sel[0];
        send_pair(ar, ai, br, bi, wr, wi, byp, last);
    endtask

    task automatic directed(input string name, input int ar, input int ai, input int br,
                            input int bi, input int wr, input int wi, input bit byp,
                            input int epr, input int epi, input int enr, input int eni);
        int lat;
        send_pair(ar, ai, br, bi, wr, wi, byp, (kexp == HALF - 1));
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = c;
                break;
            end
        end
        chk({name, "_latency"}, lat, 3);
        chk({name, "_p_r"}, bus.p_r, epr);
        chk({name, "_p_i"}, bus.p_i, epi);
        chk({name, "_n_r"}, bus.n_r, enr);
        chk({name, "_n_i"}, bus.n_i, eni);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 200 && q.size() != 0; c++) @(posedge clk);
        chk("drain_queue_empty", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_snap;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.a_r       = '0;
        bus.a_i       = '0;
        bus.b_r       = '0;
        bus.b_i       = '0;
        bus.tw_r      = '0;
        bus.tw_i      = '0;
        bus.tw_bypass = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_p_r", bus.p_r, 0);
        chk("rst_n_i", bus.n_i, 0);
        chk("rst_err_frame", bus.err_frame, 0);
        chk("rst_tw_addr", bus.tw_addr, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);

        // Directed arithmetic
        directed("real_mul", 10, 0, 4, 0, 256, 0, 1'b0, 448, 0, 192, 0);
        directed("minus_j", 10, 0, 4, 0, 0, -256, 1'b0, 320, -128, 320, 128);
        directed("rounding", 0, 0, 1, 0, 181, -181, 1'b0, 23, -23, -23, 23);
        directed("bypass", 10, 0, 4, -3, -100, 77, 1'b1, 448, -96, 192, 96);

        // Backpressure mid-stream
        stall_snap = n_stall;
        fork
            begin
                for (int i = 0; i < 8; i++) send_random(2);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                rdy_mode = 1;
                repeat (5) @(posedge clk);
                #1;
                rdy_mode = 0;
            end
        join
        wait_drain();
        chk("bp_stall_seen", (n_stall - stall_snap) >= 5, 1);

        // Framing: early in_last, then a correct frame
        do_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send_random(0);
        send_random(1);
        chk("early_last_err", bus.err_frame, 1);
        chk("early_last_tw_addr", bus.tw_addr, 0);
        for (int i = 0; i < 8; i++) send_random(2);
        chk("frame_end_tw_addr", bus.tw_addr, 0);
        wait_drain();
        chk("err_sticky", bus.err_frame, 1);

        // Reset with pairs in flight
        for (int i = 0; i < 3; i++) send_random(2);
        chk("pre_rst_out_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_err_frame", bus.err_frame, 0);
        chk("mid_rst_p_r", bus.p_r, 0);
        chk("mid_rst_tw_addr", bus.tw_addr, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale", bus.out_valid, 0);
        end
        @(posedge clk);
        #1;
        chk("post_rst_first_tw_addr", bus.tw_addr, 0);
        send_random(2);
        wait_drain();

        // Randomised stream with random backpressure and input bubbles
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_random(2);
        end
        rdy_mode = 0;
        wait_drain();
        chk("final_err_frame", bus.err_frame, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
